// File: rtl/epcs_prog_sequencer.sv
// EPCS16 reprogramming sequencer: bulk erase on request, then one 256-byte
// page per program packet drained from the EPCS Rx FIFO into the flash writer,
// pacing the PC with send_more and reporting erase / programming completion.
module epcs_prog_sequencer #(
    parameter int          PAGE_BYTES    = 256,
    parameter logic [26:0] ERASE_TIMEOUT = 27'h7FFFFFF,
    parameter int          ADDR_W        = 24
) (
    input  logic              rx_clock,
    input  logic              reset_n,
    input  logic              erase,
    output logic              erase_ACK,
    output logic              erase_err,
    input  logic [31:0]       num_blocks,
    input  logic [9:0]        EPCS_wrused,
    output logic              EPCS_rdreq,
    input  logic [7:0]        EPCS_data,
    output logic              flash_req,
    output logic              flash_op,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [7:0]        flash_wdata,
    output logic              flash_wvalid,
    input  logic              flash_ready,
    input  logic              flash_done,
    output logic              send_more,
    input  logic              send_more_ACK,
    output logic              program_done,
    output logic              busy
);

    localparam int               PG_SH    = $clog2(PAGE_BYTES);
    localparam int               CNT_W    = PG_SH + 1;
    localparam logic [CNT_W-1:0] PAGE_CNT = CNT_W'(PAGE_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAGE_BYTES - 1);
    localparam logic [9:0]       PAGE_LVL = 10'(PAGE_BYTES);

    typedef enum logic [2:0] {
        IDLE, ERASE_RUN, PROG_WAIT, PROG_RUN, PROG_FLUSH, SEND_MORE
    } state_t;

    state_t            state_q, state_d;
    logic              erase_prev_q, erase_prev_d;
    logic [26:0]       timer_q, timer_d;
    logic [31:0]       blk_q, blk_d;
    logic [31:0]       nb_q, nb_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              hold_vld_q, hold_vld_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              req_q, req_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              more_q, more_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              erase_rise;
    logic              accept;
    logic              rdreq;
    logic [31:0]       blk_inc;

    // The holding register doubles as the flash write-data register.
    assign erase_ACK    = ack_q;
    assign erase_err    = err_q;
    assign flash_req    = req_q;
    assign flash_op     = op_q;
    assign flash_addr   = addr_q;
    assign flash_wdata  = hold_data_q;
    assign flash_wvalid = hold_vld_q;
    assign send_more    = more_q;
    assign program_done = done_q;
    assign busy         = busy_q;
    assign EPCS_rdreq   = rdreq;

    // Handshake terms; at most one byte is ever in flight or held, so a read
    // is only launched when nothing is pending and the holder is free or
    // being drained. Entry needs a full page queued, so the FIFO cannot run dry.
    always_comb begin
        erase_rise = erase && !erase_prev_q;
        accept     = (state_q == PROG_RUN) && hold_vld_q && flash_ready;
        rdreq      = (state_q == PROG_RUN) && (rd_cnt_q < PAGE_CNT) &&
                     (EPCS_wrused != 10'd0) && !rd_pend_q &&
                     (!hold_vld_q || accept);
        blk_inc    = (&blk_q) ? blk_q : blk_q + 32'd1;
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        erase_prev_d = erase;
        timer_d      = timer_q;
        blk_d        = blk_q;
        nb_d         = nb_q;
        rd_cnt_d     = rd_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        rd_pend_d    = rdreq;
        hold_vld_d   = hold_vld_q;
        hold_data_d  = hold_data_q;
        req_d        = req_q;
        op_d         = op_q;
        addr_d       = addr_q;
        ack_d        = 1'b0;
        err_d        = err_q;
        more_d       = more_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (erase_rise) begin
                    state_d = ERASE_RUN;
                    err_d   = 1'b0;
                    blk_d   = 32'd0;
                    timer_d = 27'd1;
                    req_d   = 1'b1;
                    op_d    = 1'b0;
                end else if (EPCS_wrused >= PAGE_LVL) begin
                    state_d = PROG_WAIT;
                end
            end
            ERASE_RUN: begin
                // A completion arriving on the timeout cycle wins.
                if (flash_done) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    req_d   = 1'b0;
                end else if (timer_q == ERASE_TIMEOUT) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    timer_d = timer_q + 27'd1;
                end
            end
            PROG_WAIT: begin
                nb_d = num_blocks;
                if (num_blocks == 32'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (blk_q >= num_blocks) begin
                    state_d = IDLE;
                end else begin
                    state_d    = PROG_RUN;
                    req_d      = 1'b1;
                    op_d       = 1'b1;
                    addr_d     = ADDR_W'(blk_q << PG_SH);
                    rd_cnt_d   = '0;
                    acc_cnt_d  = '0;
                    hold_vld_d = 1'b0;
                end
            end
            PROG_RUN: begin
                if (rdreq) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_pend_q) begin
                    hold_vld_d  = 1'b1;
                    hold_data_d = EPCS_data;
                end else if (accept) begin
                    hold_vld_d = 1'b0;
                end
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == LAST_CNT) state_d = PROG_FLUSH;
                end
            end
            PROG_FLUSH: begin
                if (flash_done) begin
                    req_d = 1'b0;
                    blk_d = blk_inc;
                    if (blk_inc == nb_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEND_MORE;
                        more_d  = 1'b1;
                    end
                end
            end
            SEND_MORE: begin
                if (send_more_ACK) begin
                    state_d = IDLE;
                    more_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // All sequencer state and registered outputs; reset aborts any operation.
    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            erase_prev_q <= 1'b0;
            timer_q      <= '0;
            blk_q        <= '0;
            nb_q         <= '0;
            rd_cnt_q     <= '0;
            acc_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_data_q  <= '0;
            req_q        <= 1'b0;
            op_q         <= 1'b0;
            addr_q       <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            more_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            erase_prev_q <= erase_prev_d;
            timer_q      <= timer_d;
            blk_q        <= blk_d;
            nb_q         <= nb_d;
            rd_cnt_q     <= rd_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            rd_pend_q    <= rd_pend_d;
            hold_vld_q   <= hold_vld_d;
            hold_data_q  <= hold_data_d;
            req_q        <= req_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            more_q       <= more_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_epcs_prog_sequencer.sv
// Bench for epcs_prog_sequencer: FIFO, flash writer and PC-ack models driven
// once per cycle at the falling edge, with a byte/address scoreboard.
module tb_epcs_prog_sequencer;

    localparam int PAGE = 256;
    localparam int TO   = 1100;

    logic        rx_clock = 1'b0;
    logic        reset_n  = 1'b1;
    logic        erase = 1'b0;
    logic [31:0] num_blocks = '0;
    logic [9:0]  EPCS_wrused = '0;
    logic [7:0]  EPCS_data = '0;
    logic        flash_ready = 1'b0;
    logic        flash_done = 1'b0;
    logic        send_more_ACK = 1'b0;
    logic        erase_ACK, erase_err, EPCS_rdreq, flash_req, flash_op;
    logic [23:0] flash_addr;
    logic [7:0]  flash_wdata;
    logic        flash_wvalid, send_more, program_done, busy;

    epcs_prog_sequencer #(.ERASE_TIMEOUT(27'(TO))) dut (
        .rx_clock(rx_clock), .reset_n(reset_n), .erase(erase),
        .erase_ACK(erase_ACK), .erase_err(erase_err), .num_blocks(num_blocks),
        .EPCS_wrused(EPCS_wrused), .EPCS_rdreq(EPCS_rdreq), .EPCS_data(EPCS_data),
        .flash_req(flash_req), .flash_op(flash_op), .flash_addr(flash_addr),
        .flash_wdata(flash_wdata), .flash_wvalid(flash_wvalid),
        .flash_ready(flash_ready), .flash_done(flash_done),
        .send_more(send_more), .send_more_ACK(send_more_ACK),
        .program_done(program_done), .busy(busy)
    );

    always #5 rx_clock = ~rx_clock;

    // models and scoreboard
    logic [7:0]  fifo[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int unsigned addr_q[$];
    int  errors = 0, checks = 0;
    bit  rand_ready = 1, auto_ack = 1, done_now = 0;
    bit  rd_pend = 0;
    logic [7:0] rd_data = '0;
    int  page_acc = 0, done_cnt = 0, ack_wait = -1;
    int  n_erase_ack = 0, n_prog_done = 0, n_send_more = 0, n_flash_done = 0;
    int  n_rdreq = 0, n_underflow = 0, n_erase_req = 0, done_at_prog = 0;
    bit  sm_prev = 0, req_prev = 0;

    // One clock of the environment: observe registered outputs, drive inputs,
    // then resolve the handshakes the DUT will sample at the next rising edge.
    task automatic tick();
        @(negedge rx_clock);
        if (erase_ACK) n_erase_ack++;
        if (program_done) begin n_prog_done++; done_at_prog = n_flash_done; end
        if (send_more && !sm_prev) n_send_more++;
        if (flash_req && !req_prev) begin
            if (flash_op) addr_q.push_back(int'(flash_addr));
            else n_erase_req++;
        end
        sm_prev = send_more;
        req_prev = flash_req;
        if (rd_pend) EPCS_data = rd_data;
        EPCS_wrused = 10'(fifo.size());
        flash_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        flash_done = done_now;
        done_now = 0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) flash_done = 1'b1;
        end
        if (flash_done) n_flash_done++;
        send_more_ACK = 1'b0;
        if (send_more && auto_ack) begin
            if (ack_wait < 0) ack_wait = int'($urandom_range(0, 3));
            if (ack_wait == 0) begin send_more_ACK = 1'b1; ack_wait = -1; end
            else ack_wait--;
        end
        #1;
        rd_pend = EPCS_rdreq;
        if (EPCS_rdreq) begin
            n_rdreq++;
            if (fifo.size() == 0) n_underflow++;
            else rd_data = fifo.pop_front();
        end
        if (flash_wvalid && flash_ready) begin
            got_q.push_back(flash_wdata);
            page_acc++;
            if (page_acc == PAGE) begin
                page_acc = 0;
                done_cnt = int'($urandom_range(1, 4));
            end
        end
    endtask

    task automatic push_page(input bit seq);
        logic [7:0] b;
        for (int i = 0; i < PAGE; i++) begin
            b = seq ? 8'(i) : 8'($urandom_range(0, 255));
            fifo.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    // Runs until the send_more (sel=0) or program_done (sel=1) count reaches target.
    task automatic wait_evt(input bit sel, input int target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel ? n_prog_done : n_send_more) >= target) begin ok = 1; break; end
        end
    endtask

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({erase_ACK, erase_err, EPCS_rdreq, flash_req, flash_op, flash_wvalid,
             send_more, program_done, busy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000000", {erase_ACK, erase_err,
                     EPCS_rdreq, flash_req, flash_op, flash_wvalid, send_more, program_done, busy});
        end
        checks++;
        if (flash_addr !== 24'd0 || flash_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h want 0", flash_addr, flash_wdata);
        end
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || flash_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b req=%b want 0", busy, flash_req);
        end
    endtask

    task automatic test_erase_done();
        int k = 0, op_bad = 0, base = n_erase_ack;
        erase = 1'b1;
        for (int i = 0; i < TO + 50; i++) begin
            tick();
            if (flash_req) begin k++; if (flash_op !== 1'b0) op_bad++; end
            if (k == 1000 && flash_req) done_now = 1;
            if (erase_ACK) break;
        end
        erase = 1'b0;
        checks++;
        if (erase_ACK !== 1'b1 || erase_err !== 1'b0 || k != 1001) begin
            errors++;
            $display("FAIL erase_done: ack=%b err=%b req_cycles=%0d want 1 0 1001", erase_ACK, erase_err, k);
        end
        repeat (5) tick();
        checks++;
        if (n_erase_ack - base != 1 || op_bad != 0 || flash_req !== 1'b0) begin
            errors++;
            $display("FAIL erase_once: acks=%0d op_bad=%0d req=%b want 1 0 0", n_erase_ack - base, op_bad, flash_req);
        end
    endtask

    task automatic test_erase_timeout();
        int k = 0, base = n_erase_ack;
        erase = 1'b1;
        for (int i = 0; i < TO + 50; i++) begin
            tick();
            if (flash_req) k++;
            if (erase_ACK) break;
        end
        erase = 1'b0;
        checks++;
        if (erase_ACK !== 1'b1 || erase_err !== 1'b1 || k != TO) begin
            errors++;
            $display("FAIL erase_timeout: ack=%b err=%b req_cycles=%0d want 1 1 %0d", erase_ACK, erase_err, k, TO);
        end
        repeat (10) tick();
        checks++;
        if (erase_err !== 1'b1 || n_erase_ack - base != 1) begin
            errors++;
            $display("FAIL err_sticky: err=%b acks=%0d want 1 1", erase_err, n_erase_ack - base);
        end
    endtask

    task automatic test_erase_timeout_edge();
        int  k = 0;
        bit  clr_bad = 0;
        erase = 1'b1;
        for (int i = 0; i < TO + 50; i++) begin
            tick();
            if (flash_req) begin
                k++;
                if (k == 1 && erase_err !== 1'b0) clr_bad = 1;
            end
            if (k == TO - 1 && flash_req) done_now = 1;
            if (erase_ACK) break;
        end
        erase = 1'b0;
        checks++;
        if (erase_ACK !== 1'b1 || erase_err !== 1'b0 || k != TO || clr_bad) begin
            errors++;
            $display("FAIL erase_done_on_timeout: ack=%b err=%b req_cycles=%0d clr_bad=%0d want 1 0 %0d 0",
                     erase_ACK, erase_err, k, clr_bad, TO);
        end
        repeat (3) tick();
    endtask

    task automatic test_program();
        bit ok;
        int d, sm0 = n_send_more, pd0 = n_prog_done, fd0 = n_flash_done, ea0 = n_erase_ack;
        clear_sb();
        num_blocks = 32'd3;
        for (int p = 0; p < 3; p++) begin
            push_page(1'b1);
            if (p < 2) wait_evt(1'b0, sm0 + p + 1, 4000, ok);
            else       wait_evt(1'b1, pd0 + 1, 4000, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL program_page%0d: no completion event within budget", p); end
        end
        repeat (10) tick();
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL program_bytes: diff at %0d got n=%0d want n=%0d", d, got_q.size(), exp_q.size());
        end
        checks++;
        if (addr_q.size() != 3 || addr_q[0] != 0 || addr_q[1] != 32'h100 || addr_q[2] != 32'h200) begin
            errors++;
            $display("FAIL program_addrs: n=%0d first=%h want 3 pages at 000000 000100 000200",
                     addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'hFFFFFFFF);
        end
        checks++;
        if (n_send_more - sm0 != 2 || n_prog_done - pd0 != 1 || done_at_prog - fd0 != 3) begin
            errors++;
            $display("FAIL program_events: send_more=%0d prog_done=%0d dones_before=%0d want 2 1 3",
                     n_send_more - sm0, n_prog_done - pd0, done_at_prog - fd0);
        end
        checks++;
        if (n_underflow != 0 || n_erase_ack != ea0) begin
            errors++;
            $display("FAIL program_side: underflow=%0d erase_acks=%0d want 0 0", n_underflow, n_erase_ack - ea0);
        end
    endtask

    task automatic test_threshold();
        bit ok;
        int c = -1, d, busy_n = 0, rq0 = n_rdreq, pd0 = n_prog_done, ea0 = n_erase_ack, sm0 = n_send_more;
        logic [7:0] b;
        clear_sb();
        num_blocks = 32'd10;
        push_page(1'b0);
        b = fifo.pop_back();
        void'(exp_q.pop_back());
        for (int i = 0; i < 40; i++) begin
            if (i == 20) done_now = 1;
            tick();
            if (busy) busy_n++;
        end
        checks++;
        if (n_rdreq != rq0 || busy_n != 0 || n_prog_done != pd0 || n_erase_ack != ea0) begin
            errors++;
            $display("FAIL below_threshold: rdreqs=%0d busy=%0d done=%0d ack=%0d want all 0",
                     n_rdreq - rq0, busy_n, n_prog_done - pd0, n_erase_ack - ea0);
        end
        fifo.push_back(b);
        exp_q.push_back(b);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c < 0 && EPCS_wrused == 10'd256) c = 0;
            else if (c >= 0) c++;
            if (flash_req) break;
        end
        checks++;
        if (flash_req !== 1'b1 || flash_op !== 1'b1 || c < 0 || c > 2) begin
            errors++;
            $display("FAIL threshold_start: req=%b op=%b cycles=%0d want 1 1 <=2", flash_req, flash_op, c);
        end
        wait_evt(1'b0, sm0 + 1, 4000, ok);
        repeat (5) tick();
        d = first_diff();
        checks++;
        if (!ok || d != -1 || addr_q.size() != 1 || addr_q[0] != 32'h300) begin
            errors++;
            $display("FAIL threshold_page: ok=%0d diff=%0d addr=%h want 1 -1 000300",
                     ok, d, (addr_q.size() > 0) ? addr_q[0] : 32'hFFFFFFFF);
        end
    endtask

    task automatic test_erase_ignored();
        bit ok;
        int d, er0 = n_erase_req, ea0 = n_erase_ack, sm0 = n_send_more, pd0, rq0;
        clear_sb();
        num_blocks = 32'd10;
        push_page(1'b0);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (flash_req && flash_op) break;
        end
        erase = 1'b1;
        wait_evt(1'b0, sm0 + 1, 4000, ok);
        repeat (20) tick();
        d = first_diff();
        checks++;
        if (!ok || d != -1 || addr_q.size() != 1 || addr_q[0] != 32'h400) begin
            errors++;
            $display("FAIL erase_during_prog_page: ok=%0d diff=%0d addr=%h want 1 -1 000400",
                     ok, d, (addr_q.size() > 0) ? addr_q[0] : 32'hFFFFFFFF);
        end
        checks++;
        if (n_erase_ack != ea0 || n_erase_req != er0) begin
            errors++;
            $display("FAIL erase_ignored: acks=%0d erase_reqs=%0d want 0 0", n_erase_ack - ea0, n_erase_req - er0);
        end
        erase = 1'b0;
        // zero blocks requested with a full page waiting
        num_blocks = 32'd0;
        pd0 = n_prog_done;
        rq0 = n_rdreq;
        clear_sb();
        push_page(1'b0);
        repeat (20) tick();
        checks++;
        if (n_prog_done == pd0 || addr_q.size() != 0 || n_erase_req != er0 || n_rdreq != rq0) begin
            errors++;
            $display("FAIL zero_blocks: done=%0d pages=%0d rdreqs=%0d want >0 0 0",
                     n_prog_done - pd0, addr_q.size(), n_rdreq - rq0);
        end
        fifo.delete();
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_page();
        bit ok;
        int d, sm0;
        clear_sb();
        num_blocks = 32'd8;
        push_page(1'b0);
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (page_acc >= 100) break;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({erase_ACK, erase_err, EPCS_rdreq, flash_req, flash_op, flash_wvalid,
             send_more, program_done, busy} !== 9'd0 || flash_addr !== 24'd0) begin
            errors++;
            $display("FAIL async_reset: got %b addr=%h want 000000000 000000", {erase_ACK, erase_err,
                     EPCS_rdreq, flash_req, flash_op, flash_wvalid, send_more, program_done, busy}, flash_addr);
        end
        repeat (2) tick();
        fifo.delete();
        rd_pend = 0;
        page_acc = 0;
        done_cnt = 0;
        reset_n = 1'b1;
        repeat (3) tick();
        clear_sb();
        sm0 = n_send_more;
        push_page(1'b0);
        wait_evt(1'b0, sm0 + 1, 4000, ok);
        repeat (5) tick();
        d = first_diff();
        checks++;
        if (!ok || d != -1 || addr_q.size() != 1 || addr_q[0] != 32'h0) begin
            errors++;
            $display("FAIL after_reset_page: ok=%0d diff=%0d addr=%h want 1 -1 000000",
                     ok, d, (addr_q.size() > 0) ? addr_q[0] : 32'hFFFFFFFF);
        end
    endtask

    initial begin
        test_reset();
        test_erase_done();
        test_erase_timeout();
        test_erase_timeout_edge();
        test_program();
        test_threshold();
        test_erase_ignored();
        test_reset_mid_page();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
